// File: rtl/pipe_chain_inverter_if.sv
// pipe_chain_inverter_if: the data and handshake bundle of pipe_chain_inverter.
//   master : environment side; drives the input beat (in_valid, y, b, c) and out_ready,
//            and observes in_ready, out_valid, a_rec (and occ when built in)
//   slave  : pipe_chain_inverter side
// Signals:
//   in_valid / in_ready   input beat handshake
//   y                     forward chain result for the token (W bits)
//   b, c                  operand pairs; b[i], c[i] are the ones used by forward stage i
//   out_valid / out_ready output handshake
//   a_rec                 recovered chain input (W bits)
//   occ                   tokens in flight; exists only when PIPE_INV_OCC_EN is defined
interface pipe_chain_inverter_if #(
   parameter int unsigned D = 10,
   parameter int unsigned W = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [W-1:0]        y;
   logic [D-1:0][W-1:0] b;
   logic [D-1:0][W-1:0] c;
   logic                out_valid;
   logic                out_ready;
   logic [W-1:0]        a_rec;
`ifdef PIPE_INV_OCC_EN
   logic [$clog2(D+1)-1:0] occ;

   modport master (
      output in_valid, y, b, c, out_ready,
      input  in_ready, out_valid, a_rec, occ
   );

   modport slave (
      input  in_valid, y, b, c, out_ready,
      output in_ready, out_valid, a_rec, occ
   );
`else
   modport master (
      output in_valid, y, b, c, out_ready,
      input  in_ready, out_valid, a_rec
   );

   modport slave (
      input  in_valid, y, b, c, out_ready,
      output in_ready, out_valid, a_rec
   );
`endif
endinterface

// File: rtl/pipe_chain_inverter.sv
// pipe_chain_inverter: receive-side inverse of the pipe1 adder chain (y = x + 2*b + c per
// stage). Takes a chain result y with the D operand pairs that produced it and recovers the
// chain input a by peeling the stage terms off in reverse order, one stage per pipeline step.
// D-stage valid/ready pipeline with a single global stall; all arithmetic is modulo 2^W.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous reset, active-high; drops every in-flight token
//   bus   slave modport of pipe_chain_inverter_if (in_valid/in_ready/y/b/c,
//         out_valid/out_ready/a_rec, optional occ)
// Configuration:
//   PIPE_INV_OCC_EN  when defined, bus.occ carries a registered count of tokens in flight.
module pipe_chain_inverter #(
   parameter int unsigned D = 10,
   parameter int unsigned W = 32
) (
   input logic                  clk,
   input logic                  rst,
   pipe_chain_inverter_if.slave bus
);

   // 2*x modulo 2^W, i.e. {x[W-2:0], 1'b0}
   function automatic logic [W-1:0] dbl(input logic [W-1:0] x);
      return x << 1;
   endfunction

   logic                adv;
   logic [D-1:0]        vld_q;
   logic [D-1:0][W-1:0] acc_q;
   logic [D-1:0][W-1:0] acc_d;

   // Whole pipe moves together; a full output stage with no taker freezes everything,
   // bubbles included.
   assign adv = !vld_q[D-1] || bus.out_ready;

   // Operand pairs travelling with each token. Stage k keeps pairs 0..D-2-k; the last stage
   // needs none, so only stages 0..D-2 have carry registers.
   for (genvar k = 0; k < D - 1; k++) begin : gen_carry
      logic [D-2-k:0][W-1:0] b_q;
      logic [D-2-k:0][W-1:0] c_q;

      if (k == 0) begin : gen_head
         always_ff @(posedge clk) begin
            if (adv) begin
               b_q <= bus.b[D-2:0];
               c_q <= bus.c[D-2:0];
            end
         end
      end else begin : gen_body
         always_ff @(posedge clk) begin
            if (adv) begin
               b_q <= gen_carry[k-1].b_q[D-2-k:0];
               c_q <= gen_carry[k-1].c_q[D-2-k:0];
            end
         end
      end
   end

   // Stage 0 removes the last forward stage's term; stage k removes term D-1-k, which is the
   // top pair still carried by stage k-1.
   assign acc_d[0] = bus.y - dbl(bus.b[D-1]) - bus.c[D-1];

   for (genvar k = 1; k < D; k++) begin : gen_acc
      assign acc_d[k] = acc_q[k-1] - dbl(gen_carry[k-1].b_q[D-1-k])
                        - gen_carry[k-1].c_q[D-1-k];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
      end else if (adv) begin
         vld_q <= {vld_q[D-2:0], bus.in_valid};
      end
   end

   // Only the output accumulator is reset so a_rec reads 0 after reset; the others are
   // don't-care while their valid bit is clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q[D-1] <= '0;
      end else if (adv) begin
         acc_q <= acc_d;
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[D-1];
   assign bus.a_rec     = acc_q[D-1];

`ifdef PIPE_INV_OCC_EN
   localparam int unsigned OccW = $clog2(D + 1);

   logic            accept;
   logic            pop;
   logic [OccW-1:0] occ_q;
   logic [OccW-1:0] occ_d;

   assign accept = bus.in_valid && adv;
   assign pop    = vld_q[D-1] && bus.out_ready;

   // Accept and pop in the same cycle cancel out.
   always_comb begin
      occ_d = occ_q;
      if (accept && !pop) begin
         occ_d = occ_q + OccW'(1);
      end else if (!accept && pop) begin
         occ_d = occ_q - OccW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign bus.occ = occ_q;
`endif

endmodule
